// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: controller <-> instruction memory / register file bus.
interface cpu_ctrl_fsm_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic [7:0]      q1;
  logic [7:0]      q2;
  logic [1:0]      n1;
  logic [1:0]      n2;
  logic [1:0]      nd;
  logic [7:0]      di;
  logic            reg_we;
  modport master (output imem_addr, n1, n2, nd, di, reg_we, input imem_data, q1, q2);
  modport slave  (input imem_addr, n1, n2, nd, di, reg_we, output imem_data, q1, q2);
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/execute controller with an 8-bit ALU,
// driving a 4x8 register file and an instruction memory.
module cpu_ctrl_fsm #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  cpu_ctrl_fsm_if.master bus,
  output logic           busy_o,
  output logic           halted_o,
  output logic           zflag_o,
  output logic           cflag_o
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, IMM, EXEC, WB, HALT} state_t;
  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                         OP_MOV = 4'h5, OP_LDI = 4'h6, OP_JMP = 4'h7, OP_JZ = 4'h8,
                         OP_HALT = 4'hF;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      ir_q, ir_d, a_q, a_d, b_q, b_d, r_q, r_d;
  logic            z_q, z_d, c_q, c_d;
  logic [3:0]      op;
  logic [8:0]      sum;
  logic [7:0]      alu_r;
  logic            alu_c;
  assign op     = ir_q[7:4];
  assign pc_inc = pc_q + PC_W'(1);
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    alu_r = op == OP_ADD ? sum[7:0] :
            op == OP_SUB ? a_q - b_q :
            op == OP_AND ? a_q & b_q :
            op == OP_OR  ? a_q | b_q : b_q;
    alu_c = op == OP_ADD ? sum[8] : (op == OP_SUB) && (a_q < b_q);
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    z_d     = z_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE:   state_d = start_i ? FETCH : IDLE;
      FETCH: begin
        ir_d    = bus.imem_data;
        pc_d    = pc_inc;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = bus.q1;
        b_d     = bus.q2;
        state_d = op == OP_HALT ? HALT :
                  (op == OP_LDI || op == OP_JMP || op == OP_JZ) ? IMM :
                  (op >= OP_ADD && op <= OP_MOV) ? EXEC : FETCH;
      end
      IMM: begin
        pc_d = pc_inc;
        if (op == OP_LDI) begin
          r_d     = bus.imem_data;
          z_d     = bus.imem_data == 8'h00;
          state_d = WB;
        end else begin
          state_d = FETCH;
          // JMP always, JZ only when Z; the jump overrides the increment
          if (op == OP_JMP || (op == OP_JZ && z_q)) pc_d = bus.imem_data[PC_W-1:0];
        end
      end
      EXEC: begin
        r_d     = alu_r;
        z_d     = alu_r == 8'h00;
        c_d     = alu_c;
        state_d = WB;
      end
      WB:     state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end
  assign bus.imem_addr = pc_q;
  assign bus.n1        = ir_q[3:2];
  assign bus.n2        = ir_q[1:0];
  assign bus.nd        = ir_q[3:2];
  assign bus.di        = r_q;
  assign bus.reg_we    = state_q == WB;
  assign busy_o        = state_q != IDLE && state_q != HALT;
  assign halted_o      = state_q == HALT;
  assign zflag_o       = z_q;
  assign cflag_o       = c_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: program-level vectors with a register-file write scoreboard,
// plus hand sequences for write timing, mid-instruction reset and HALT.
module tb_cpu_ctrl_fsm;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, halted, zf, cf;
  int checks = 0, failures = 0;
  logic [7:0] rom [256];
  logic [7:0] rf [4];
  logic [9:0] exp_q [$];
  logic [7:0] forbid = 8'h80;
  logic seen_forbid = 1'b0;

  cpu_ctrl_fsm_if #(.PC_W(8)) bus ();
  cpu_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bus(bus),
    .busy_o(busy), .halted_o(halted), .zflag_o(zf), .cflag_o(cf));

  always #5 clk = ~clk;

  // register file model: r0=11, r1=22 after reset, writes on the WB edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf[0] <= 8'd11; rf[1] <= 8'd22; rf[2] <= 8'd0; rf[3] <= 8'd0;
    end else if (bus.reg_we) rf[bus.nd] <= bus.di;
  assign bus.q1 = rf[bus.n1];
  assign bus.q2 = rf[bus.n2];
  assign bus.imem_data = rom[bus.imem_addr];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy && bus.imem_addr == forbid) seen_forbid = 1'b1;
    if (rst_n && bus.reg_we) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=nd%0d/di%h required=no write", bus.nd, bus.di);
      end else chk("write_nd_di", {22'b0, bus.nd, bus.di}, {22'b0, exp_q.pop_front()});
    end
  end

  typedef struct {
    string       name;
    logic [63:0] prog;
    logic [7:0]  seg_addr;
    logic [23:0] seg;
    logic [7:0]  forbid;
    int          nw;
    logic [3:0][9:0] wr;
    logic [31:0] regs;
    logic        z, c;
  } vec_t;

  task automatic load(input logic [63:0] prog, input logic [7:0] seg_addr, input logic [23:0] seg);
    for (int i = 0; i < 256; i++) rom[i] = 8'h5D;
    for (int i = 0; i < 8; i++) rom[i] = prog[63-8*i -: 8];
    for (int j = 0; j < 3; j++) begin
      logic [7:0] a;
      a = seg_addr + 8'(j);
      rom[a] = seg[23-8*j -: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    seen_forbid = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, input bit toggle);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
      start = (toggle && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    if (!halted) begin
      checks++; failures++;
      $display("FAIL halt_timeout actual=not halted required=halted within %0d cycles", budget);
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"add",        64'h11F05D5D5D5D5D5D, 8'h80, 24'h5D5D5D, 8'h03, 1,
                {10'h0, 10'h0, 10'h0, 10'h021}, 32'h0000160B | 32'h00000021 & 32'h00001621, 1'b0, 1'b0};
    vecs[0].regs = 32'h00001621;
    vecs[1] = '{"ldi_add_c",  64'h68FF19F05D5D5D5D, 8'h80, 24'h5D5D5D, 8'h05, 2,
                {10'h0, 10'h0, 10'h215, 10'h2FF}, 32'h0015160B, 1'b0, 1'b1};
    vecs[2] = '{"sub_jz_tk",  64'h512180105D5D5D5D, 8'h10, 24'hF05D5D, 8'h05, 2,
                {10'h0, 10'h0, 10'h000, 10'h016}, 32'h00001600, 1'b1, 1'b0};
    vecs[3] = '{"jz_not_tk",  64'h802011F05D5D5D5D, 8'h20, 24'hF05D5D, 8'h20, 1,
                {10'h0, 10'h0, 10'h0, 10'h021}, 32'h00001621, 1'b0, 1'b0};
    vecs[4] = '{"jmp_wrap",   64'h800670FD5D5DF05D, 8'hFD, 24'h006C00, 8'h05, 1,
                {10'h0, 10'h0, 10'h0, 10'h300}, 32'h0000160B, 1'b1, 1'b0};
    vecs[5] = '{"undef_nop",  64'h21A5F05D5D5D5D5D, 8'h80, 24'h5D5D5D, 8'h04, 1,
                {10'h0, 10'h0, 10'h0, 10'h0F5}, 32'h000016F5, 1'b0, 1'b1};
    vecs[6] = '{"and_or_dbl", 64'h6CF0334715F05D5D, 8'h80, 24'h5D5D5D, 8'h07, 4,
                {10'h1EC, 10'h1F6, 10'h000, 10'h3F0}, 32'hF000EC00, 1'b0, 1'b1};

    // reset values
    load(vecs[0].prog, vecs[0].seg_addr, vecs[0].seg);
    do_reset();
    chk("rst_ctrl", {27'b0, bus.reg_we, busy, halted, zf, cf}, 32'h0);
    chk("rst_bus", {10'b0, bus.imem_addr, bus.di, bus.n1, bus.n2, bus.nd}, 32'h0);
    repeat (3) @(negedge clk);
    chk("idle_no_start", {31'b0, busy}, 32'h0);

    // reg_we pulses exactly in the 4th cycle after leaving IDLE
    exp_q.push_back(10'h021);
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("we_cycle%0d", k), {31'b0, bus.reg_we}, {31'b0, k == 4});
      if (k == 1) chk("busy_fetch", {31'b0, busy}, 32'h1);
      if (k == 4) chk("wb_nd_di_flags", {20'b0, bus.nd, bus.di, zf, cf}, {20'b0, 2'd0, 8'h21, 2'b00});
    end
    run_to_halt(50, 1'b0);
    chk("add_r0", {24'b0, rf[0]}, 32'h21);
    // start held in HALT has no effect
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt_sticky", {29'b0, halted, busy, 1'b0}, 32'h4);
    chk("halt_pc", {24'b0, bus.imem_addr}, 32'h02);
    start = 1'b0;

    // program vectors
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      load(v.prog, v.seg_addr, v.seg);
      do_reset();
      forbid = v.forbid;
      for (int w = 0; w < v.nw; w++) exp_q.push_back(v.wr[w]);
      start = 1'b1;
      run_to_halt(400, 1'b1);
      @(negedge clk);
      for (int r = 0; r < 4; r++)
        chk($sformatf("%s_r%0d", v.name, r), {24'b0, rf[r]}, {24'b0, v.regs[8*r +: 8]});
      chk({v.name, "_zc"}, {30'b0, zf, cf}, {30'b0, v.z, v.c});
      chk({v.name, "_halt"}, {30'b0, halted, busy}, 32'h2);
      chk({v.name, "_pending_writes"}, exp_q.size(), 32'h0);
      chk({v.name, "_forbidden_addr"}, {31'b0, seen_forbid}, 32'h0);
    end
    forbid = 8'h80;

    // reset during EXEC aborts the ADD with no write
    load(vecs[0].prog, vecs[0].seg_addr, vecs[0].seg);
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {27'b0, bus.reg_we, busy, halted, zf, cf}, 32'h0);
    chk("abort_bus", {10'b0, bus.imem_addr, bus.di, bus.n1, bus.n2, bus.nd}, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_r0", {24'b0, rf[0]}, 32'h0B);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", {23'b0, busy, bus.imem_addr}, 32'h0);
    exp_q.push_back(10'h021);
    start = 1'b1;
    run_to_halt(50, 1'b0);
    @(negedge clk);
    chk("rerun_r0", {24'b0, rf[0]}, 32'h21);
    chk("rerun_pending", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle fetch/decode/execute controller with an integrated 8-bit ALU. It sits directly upstream of the 4x8 register file.
- Drives the register file's read ports (n1, n2), write port (nd, di, reg_we) and the instruction-memory address.
- Consumes the register file's combinational read data (q1, q2).
- Runs programs of 8-bit instructions, some followed by an immediate byte.

Parameters:
PC_W, 8, program counter / instruction memory address width (PC wraps modulo 2^PC_W)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  level; in IDLE, start=1 begins execution; ignored in all other states
imem_addr  output  PC_W  instruction memory address, equals PC
imem_data  input  8  instruction memory read data, combinational (valid same cycle as imem_addr)
q1  input  8  register file read data for n1 (combinational)
q2  input  8  register file read data for n2 (combinational)
n1  output  2  read select 1 = IR[3:2] (rd)
n2  output  2  read select 2 = IR[1:0] (rs)
nd  output  2  write select = IR[3:2] (rd)
di  output  8  write data = result register R
reg_we  output  1  write enable, high only in WB
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
zflag  output  1  zero flag
cflag  output  1  carry/borrow flag

Behaviour:
- Instruction byte: op=IR[7:4], rd=IR[3:2], rs=IR[1:0].
- Opcodes:
  - 0x1 ADD: rd=rd+rs
  - 0x2 SUB: rd=rd-rs
  - 0x3 AND
  - 0x4 OR
  - 0x5 MOV: rd=rs
  - 0x6 LDI: rd=imm
  - 0x7 JMP: PC=imm
  - 0x8 JZ: if Z then PC=imm
  - 0xF HALT
  - 0x0 and all undefined opcodes execute as NOP.
- Immediate: the byte following the instruction; PC advances past it.
- Reset (async):
  - state=IDLE, PC=RESET_PC, IR=0, A=B=R=IMM=0, Z=C=0.
  - Outputs: reg_we=0, busy=0, halted=0, di=0, n1=n2=nd=0, imem_addr=RESET_PC.
  - Reset mid-instruction aborts it with no register write.
- FSM (one state per cycle):
  - IDLE: start=1 -> FETCH; else stay.
  - FETCH: IR<=imem_data, PC<=PC+1 -> DECODE.
  - DECODE: A<=q1, B<=q2.
    - HALT -> HALT.
    - LDI/JMP/JZ -> IMM.
    - NOP/undefined -> FETCH.
    - else -> EXEC.
  - IMM: IMM<=imem_data, PC<=PC+1.
    - LDI: R<=imem_data, Z<=(imem_data==0), C unchanged -> WB.
    - JMP: PC<=imem_data[PC_W-1:0] (overrides increment) -> FETCH.
    - JZ: PC<=Z ? imem_data[PC_W-1:0] : PC+1 -> FETCH.
  - EXEC: R<=alu(A,B), update Z and C -> WB.
  - WB: reg_we=1 for exactly this cycle, nd=rd, di=R; register written on the exiting edge -> FETCH.
  - HALT: stay until rst_n; halted=1, busy=0, start ignored.
- ALU, 8-bit, result truncated:
  - ADD: C=carry out of bit 7.
  - SUB: C=1 iff A<B unsigned (borrow).
  - AND/OR/MOV: C=0.
  - Z=(result==0) for all ALU ops.
- Flags: Z and C change only in EXEC, and Z in IMM for LDI. JMP, JZ, NOP and HALT preserve flags.
- Cycle counts:
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI: 4 cycles (FETCH, DECODE, IMM, WB).
  - JMP/JZ: 3 cycles.
  - NOP: 2 cycles.
- Read-after-write: the register file writes on the WB edge, so the next DECODE sees the new value; no forwarding is required.
- rd==rs is legal (e.g. ADD r1,r1 doubles r1).
- Wrap-around: PC increments wrap from 2^PC_W-1 to 0, including an immediate fetched at address 2^PC_W-1.
- n1, n2 and nd are combinational from IR; reg_we, busy and halted are decoded from state only (Moore).

Test Plan:
- Bench pairing: the team register file (reset contents r0=11, r1=22, r2=r3=0) plus a ROM model.
- ADD: program 0x11, 0xF0; start=1 -> reg_we high exactly in the 4th cycle after leaving IDLE with nd=0, di=33, Z=0, C=0; r0=33; then halted=1.
- LDI + ADD carry: program 0x68 0xFF, 0x19 -> r2=0xFF, then r2=0xFF+22=0x15, C=1, Z=0.
- SUB/JZ taken: program 0x51 (MOV r0,r1 -> r0=22), 0x21 (r0=0, Z=1, C=0), 0x80 0x10, at 0x10: 0xF0 -> PC jumps to 0x10, halted=1; the byte at 0x05 is never fetched.
- JZ not taken + JMP: after Z=0, 0x80 0x20 falls through to PC+2; JMP 0x70 0x00 loops to 0; PC wraps 0xFF->0x00 for a NOP (0x00) at 0xFF.
- Reset mid-operation: assert rst_n=0 during EXEC of ADD -> reg_we never pulses, register contents unchanged, all outputs at reset values, state IDLE; restart with start=1 re-runs from RESET_PC.
- Undefined opcode 0xA5 -> 2-cycle NOP, no reg_we, flags unchanged; start toggled while busy has no effect.
